// File: rtl/reg_file_pkg.sv
// Shared types and default widths for the scanning register file.
package reg_file_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned AW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/reg_file_core.sv
// Storage array with one write port, a gated host read port and an ungated scan read port.
module reg_file_core #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          W_en,
    input  logic [AW-1:0] W_Addr,
    input  logic [DW-1:0] W_Data,
    input  logic          R_en,
    input  logic [AW-1:0] R_Addr,
    output logic [DW-1:0] R_Data,
    input  logic [AW-1:0] scan_addr,
    output logic [DW-1:0] scan_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mem <= '{default: '0};
        end else if (W_en) begin
            mem[W_Addr] <= W_Data;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not observed.
    assign R_Data    = R_en ? mem[R_Addr] : '0;
    assign scan_data = mem[scan_addr];

endmodule

// File: rtl/reg_file_scan.sv
// Register file with a one-shot scan engine reporting max/min (and optionally sum).
// Optional feature macro: REGFILE_SCAN_SUM_EN adds the Sum port and accumulator.
module reg_file_scan
    import reg_file_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          W_en,
    input  logic [AW-1:0] W_Addr,
    input  logic [DW-1:0] W_Data,
    input  logic          R_en,
    input  logic [AW-1:0] R_Addr,
    output logic [DW-1:0] R_Data,
    input  logic          Start,
    output logic          Busy,
    output logic          Done,
    output logic [DW-1:0] Max_Val,
    output logic [AW-1:0] Max_Addr,
    output logic [DW-1:0] Min_Val,
    output logic [AW-1:0] Min_Addr
`ifdef REGFILE_SCAN_SUM_EN
    ,
    output logic [DW+AW-1:0] Sum
`endif
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned SW    = DW + AW;

    scan_state_t   state;
    logic [AW-1:0] idx;
    logic [DW-1:0] scan_data;
    logic [DW-1:0] work_max;
    logic [AW-1:0] work_max_addr;
    logic [DW-1:0] work_min;
    logic [AW-1:0] work_min_addr;
`ifdef REGFILE_SCAN_SUM_EN
    logic [SW-1:0] work_sum;
`endif

    reg_file_core #(
        .DW(DW),
        .AW(AW)
    ) u_core (
        .Clk      (Clk),
        .Rst      (Rst),
        .W_en     (W_en),
        .W_Addr   (W_Addr),
        .W_Data   (W_Data),
        .R_en     (R_en),
        .R_Addr   (R_Addr),
        .R_Data   (R_Data),
        .scan_addr(idx),
        .scan_data(scan_data)
    );

    // Scan FSM: IDLE -> SCAN (DEPTH cycles) -> DONE (publish) -> IDLE.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            idx           <= '0;
            work_max      <= '0;
            work_max_addr <= '0;
            work_min      <= '0;
            work_min_addr <= '0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            Max_Val       <= '0;
            Max_Addr      <= '0;
            Min_Val       <= '0;
            Min_Addr      <= '0;
`ifdef REGFILE_SCAN_SUM_EN
            work_sum      <= '0;
            Sum           <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state         <= SCAN;
                        idx           <= '0;
                        work_max      <= '0;
                        work_max_addr <= '0;
                        work_min      <= '0;
                        work_min_addr <= '0;
                        Busy          <= 1'b1;
`ifdef REGFILE_SCAN_SUM_EN
                        work_sum      <= '0;
`endif
                    end
                end
                SCAN: begin
                    // Entry 0 seeds both extremes; strict compares keep the lowest address on ties.
                    if ((idx == '0) || (scan_data > work_max)) begin
                        work_max      <= scan_data;
                        work_max_addr <= idx;
                    end
                    if ((idx == '0) || (scan_data < work_min)) begin
                        work_min      <= scan_data;
                        work_min_addr <= idx;
                    end
`ifdef REGFILE_SCAN_SUM_EN
                    work_sum <= work_sum + SW'(scan_data);
`endif
                    if (idx == AW'(DEPTH - 1)) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                DONE: begin
                    Max_Val  <= work_max;
                    Max_Addr <= work_max_addr;
                    Min_Val  <= work_min;
                    Min_Addr <= work_min_addr;
`ifdef REGFILE_SCAN_SUM_EN
                    Sum      <= work_sum;
`endif
                    Done     <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
